// File: rtl/sram16_resp.sv
// sram16_resp: serves one 32-bit LSU data request as two 16-bit accesses
// on an external asynchronous SRAM (low half-word first, then high).
// Every SRAM-facing output comes straight from a register.
// Optional feature macro: SRAM_BMASK_EN (honour i_bmask on writes); when
// undefined, every write is a full-word store.
module sram16_resp #(
  parameter int ADDR_W   = 18,
  parameter int WAIT_CYC = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_bmask,
  input  logic              i_wren,
  input  logic              i_rden,
  output logic [31:0]       o_rdata,
  output logic              o_ack,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [15:0]       io_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  // Last count of a phase; count 0 is the setup cycle.
  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYC);
  localparam int         WI_W     = ADDR_W - 1;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [WI_W-1:0]   word_q, word_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [31:0]       rdata_q, rdata_d;
`ifdef SRAM_BMASK_EN
  logic [3:0]        bmask_q, bmask_d;
`endif

  // Registered pin state.
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic              ce_n_q, ce_n_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              lb_n_q, lb_n_d;
  logic              ub_n_q, ub_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic [15:0]       dq_out_q, dq_out_d;

  // Helpers for the pin decode.
  logic              hi_phase;
  logic [1:0]        phase_mask;

  // Byte address bits outside the word index are deliberately unused.
`ifdef SRAM_BMASK_EN
  logic unused_bits;
  assign unused_bits = ^{i_addr[31:ADDR_W+1], i_addr[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{i_addr[31:ADDR_W+1], i_addr[1:0], i_bmask};
`endif

  // FSM next state, request latching and read-data capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
`ifdef SRAM_BMASK_EN
    bmask_d = bmask_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_wren || i_rden) begin
          state_d = S_LO;
          cnt_d   = 3'd0;
          word_d  = i_addr[ADDR_W:2];
          wdata_d = i_wdata;
          wr_d    = i_wren;          // write wins when both strobes are high
`ifdef SRAM_BMASK_EN
          bmask_d = i_bmask;
`endif
        end
      end
      S_LO: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_HI;
          cnt_d   = 3'd0;
          if (!wr_q) rdata_d[15:0] = io_sram_dq;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_HI: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_ACK;
          cnt_d   = 3'd0;
          if (!wr_q) rdata_d[31:16] = io_sram_dq;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Pin decode from the upcoming state, so the pins are registered yet aligned with the phase.
  always_comb begin
    sram_addr_d = sram_addr_q;
    ce_n_d      = 1'b1;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    lb_n_d      = 1'b1;
    ub_n_d      = 1'b1;
    dq_oe_d     = 1'b0;
    dq_out_d    = dq_out_q;
    hi_phase    = (state_d == S_HI);
`ifdef SRAM_BMASK_EN
    phase_mask  = hi_phase ? bmask_d[3:2] : bmask_d[1:0];
`else
    phase_mask  = 2'b11;
`endif
    if (state_d == S_LO || state_d == S_HI) begin
      sram_addr_d = {word_d, hi_phase};
      ce_n_d      = 1'b0;
      if (wr_d) begin
        dq_oe_d  = 1'b1;
        dq_out_d = hi_phase ? wdata_d[31:16] : wdata_d[15:0];
        lb_n_d   = ~phase_mask[0];
        ub_n_d   = ~phase_mask[1];
        // Strobe only after the setup cycle, and never for a fully masked phase.
        we_n_d   = ~((cnt_d != 3'd0) && (|phase_mask));
      end else begin
        oe_n_d = 1'b0;
        lb_n_d = 1'b0;
        ub_n_d = 1'b0;
      end
    end
  end

  // State and pin registers; reset aborts any access in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      word_q      <= '0;
      wdata_q     <= 32'd0;
      wr_q        <= 1'b0;
      rdata_q     <= 32'd0;
`ifdef SRAM_BMASK_EN
      bmask_q     <= 4'd0;
`endif
      sram_addr_q <= '0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      rdata_q     <= rdata_d;
`ifdef SRAM_BMASK_EN
      bmask_q     <= bmask_d;
`endif
      sram_addr_q <= sram_addr_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      lb_n_q      <= lb_n_d;
      ub_n_q      <= ub_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign o_rdata     = rdata_q;
  assign o_ack       = (state_q == S_ACK);
  assign o_busy      = (state_q != S_IDLE);
  assign o_sram_addr = sram_addr_q;
  assign o_sram_ce_n = ce_n_q;
  assign o_sram_we_n = we_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_lb_n = lb_n_q;
  assign o_sram_ub_n = ub_n_q;
  assign io_sram_dq  = dq_oe_q ? dq_out_q : 16'hzzzz;

endmodule
